// File: rtl/store_queue_if.sv
// Store queue port bundle: dispatch, execute, retire/squash, load lookup and D-cache write port.
// Latency: none, wires only; the queue registers the lookup response one cycle after ld_valid.
// Backpressure: disp_ready gates allocation; mem_wr_ack pops the head write, which holds until then.
interface store_queue_if #(
    parameter int SQ_SIZE = 8,
    parameter int XLEN    = 32
);
    localparam int PW = $clog2(SQ_SIZE);

    // dispatch
    logic            disp_valid;
    logic            disp_ready;
    logic [PW-1:0]   disp_idx;
    // execute
    logic            ex_valid;
    logic [PW-1:0]   ex_idx;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_data;
    // retire / flush
    logic            rt_valid;
    logic            squash;
    // load lookup
    logic            ld_valid;
    logic [XLEN-1:0] ld_addr;
    logic [PW-1:0]   ld_age;
    logic            ld_resp_valid;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic            fwd_stall;
    // D-cache write port
    logic            mem_wr_valid;
    logic [XLEN-1:0] mem_wr_addr;
    logic [XLEN-1:0] mem_wr_data;
    logic            mem_wr_ack;

    // Pipeline side: dispatch/execute/ROB/load unit/cache
    modport master (
        output disp_valid, ex_valid, ex_idx, ex_addr, ex_data,
        output rt_valid, squash, ld_valid, ld_addr, ld_age, mem_wr_ack,
        input  disp_ready, disp_idx, ld_resp_valid, fwd_hit, fwd_data, fwd_stall,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    // Store queue side
    modport slave (
        input  disp_valid, ex_valid, ex_idx, ex_addr, ex_data,
        input  rt_valid, squash, ld_valid, ld_addr, ld_age, mem_wr_ack,
        output disp_ready, disp_idx, ld_resp_valid, fwd_hit, fwd_data, fwd_stall,
        output mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/store_queue.sv
// Circular store queue with load forwarding (SQ_FWD_EN) and in-order drain to the D-cache.
// Latency: lookup result registered, valid one cycle after ld_valid; drain write offered combinationally from head.
// Backpressure: disp_ready=~full from registered count; head write held stable until mem_wr_ack.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

`ifdef SQ_FWD_EN
// Priority selector: first requester found scanning from ptr toward lower indices, wrapping.
module binary_pselect_dir0 #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);
    // Walk farthest-first so the requester closest to ptr is the last to overwrite the grant.
    always_comb begin
        logic [PW-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr - PW'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
endmodule
`endif

module store_queue #(
    parameter int SQ_SIZE = `SQ_SIZE,
    parameter int XLEN    = 32
) (
    input logic   clock,
    input logic   reset_n,
    store_queue_if.slave sq
);
    localparam int PW = $clog2(SQ_SIZE);
    localparam int CW = PW + 1;

    // pointers and occupancy; ccount = committed but not yet drained
    logic [PW-1:0] head, commit, tail;
    logic [CW-1:0] count, ccount;

    // per-entry state
    logic [SQ_SIZE-1:0] valid, resolved, committed;
    logic [XLEN-1:0]    addr [SQ_SIZE];
    logic [XLEN-1:0]    data [SQ_SIZE];

    logic full;
    logic do_disp, do_ex, do_rt, do_ack;

    // lookup terms
    logic [PW-1:0]      win_len;
    logic [PW-1:0]      rel [SQ_SIZE];
    logic [SQ_SIZE-1:0] in_win, unres, match;
    logic               stall_c, hit_c;
    logic [XLEN-1:0]    data_c;
    logic [1:0]         unused_ld_lo;

    assign full    = (count == CW'(SQ_SIZE));
    assign do_ack  = sq.mem_wr_valid & sq.mem_wr_ack;
    assign do_disp = sq.disp_valid & ~full & ~sq.squash;
    // A drain-ready entry ignores re-execution so the write port never changes under the cache.
    assign do_ex   = sq.ex_valid & ~sq.squash & valid[sq.ex_idx]
                     & ~(committed[sq.ex_idx] & resolved[sq.ex_idx]);
    assign do_rt   = sq.rt_valid & ~sq.squash & (count > ccount);

    assign sq.disp_ready   = ~full;
    assign sq.disp_idx     = tail;
    assign sq.mem_wr_valid = valid[head] & committed[head] & resolved[head];
    assign sq.mem_wr_addr  = addr[head];
    assign sq.mem_wr_data  = data[head];

    // Stores are full-word and word-aligned; byte offset of the load plays no part in matching.
    assign unused_ld_lo = sq.ld_addr[1:0];

    // Pointer and occupancy update; a squash rewinds tail to the commit point but still honours a drain pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            commit <= '0;
            tail   <= '0;
            count  <= '0;
            ccount <= '0;
        end else begin
            head <= head + PW'(do_ack);
            if (sq.squash) begin
                tail   <= commit;
                count  <= ccount - CW'(do_ack);
                ccount <= ccount - CW'(do_ack);
            end else begin
                tail   <= tail + PW'(do_disp);
                commit <= commit + PW'(do_rt);
                count  <= count + CW'(do_disp) - CW'(do_ack);
                ccount <= ccount + CW'(do_rt) - CW'(do_ack);
            end
        end
    end

    // Entry status bits: drain clears the head, squash kills uncommitted entries, else dispatch/execute/retire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid     <= '0;
            resolved  <= '0;
            committed <= '0;
        end else begin
            for (int i = 0; i < SQ_SIZE; i++) begin
                if (do_ack && head == PW'(i)) begin
                    valid[i]     <= 1'b0;
                    resolved[i]  <= 1'b0;
                    committed[i] <= 1'b0;
                end else if (sq.squash) begin
                    if (!committed[i]) begin
                        valid[i]    <= 1'b0;
                        resolved[i] <= 1'b0;
                    end
                end else begin
                    if (do_disp && tail == PW'(i)) begin
                        valid[i]     <= 1'b1;
                        resolved[i]  <= 1'b0;
                        committed[i] <= 1'b0;
                    end
                    if (do_ex && sq.ex_idx == PW'(i))
                        resolved[i] <= 1'b1;
                    if (do_rt && commit == PW'(i))
                        committed[i] <= 1'b1;
                end
            end
        end
    end

    // Address/data payload; only meaningful while the resolved bit is set, so no reset needed.
    always_ff @(posedge clock) begin
        if (do_ex) begin
            addr[sq.ex_idx] <= sq.ex_addr;
            data[sq.ex_idx] <= sq.ex_data;
        end
    end

    assign win_len = sq.ld_age - head;

    // Age of each entry relative to head; an entry is older than the load when its age is below win_len.
    always_comb begin
        for (int i = 0; i < SQ_SIZE; i++) begin
            rel[i]    = PW'(i) - head;
            in_win[i] = valid[i] && (rel[i] < win_len);
            unres[i]  = in_win[i] && !resolved[i];
            match[i]  = in_win[i] && resolved[i]
                        && (addr[i][XLEN-1:2] == sq.ld_addr[XLEN-1:2]);
        end
    end

`ifdef SQ_FWD_EN
    logic [PW-1:0] sel_ptr, sel_idx;
    logic          sel_vld;
    logic          younger_unres;

    assign sel_ptr = sq.ld_age - PW'(1);

    binary_pselect_dir0 #(.N(SQ_SIZE), .PW(PW)) u_sel (
        .req       (match),
        .ptr       (sel_ptr),
        .gnt_valid (sel_vld),
        .gnt_idx   (sel_idx)
    );

    // An unresolved store younger than the chosen source could still overwrite it.
    always_comb begin
        younger_unres = 1'b0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            if (unres[i] && (rel[i] > rel[sel_idx]))
                younger_unres = 1'b1;
        end
    end

    assign stall_c = sel_vld ? younger_unres : (|unres);
    assign hit_c   = sel_vld & ~stall_c;
    assign data_c  = hit_c ? data[sel_idx] : '0;
`else
    // Without forwarding any possible dependence on an older store makes the load retry.
    assign stall_c = |(unres | match);
    assign hit_c   = 1'b0;
    assign data_c  = '0;
`endif

    // Lookup response register: one-cycle pulse following ld_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sq.ld_resp_valid <= 1'b0;
            sq.fwd_hit       <= 1'b0;
            sq.fwd_stall     <= 1'b0;
            sq.fwd_data      <= '0;
        end else begin
            sq.ld_resp_valid <= sq.ld_valid;
            sq.fwd_hit       <= sq.ld_valid & hit_c;
            sq.fwd_stall     <= sq.ld_valid & stall_c;
            sq.fwd_data      <= sq.ld_valid ? data_c : '0;
        end
    end

    // The ROB may only retire a store the queue still holds uncommitted.
    assert property (@(posedge clock) disable iff (!reset_n)
                     (sq.rt_valid && !sq.squash) |-> (count > ccount));

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios then random traffic against a list-based reference model.
// Latency: model predicts lookup responses one cycle after ld_valid.
// Backpressure: model honours full-queue dispatch drops and ack-gated drain.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

module tb_store_queue;
    localparam int N  = `SQ_SIZE;
    localparam int PW = $clog2(N);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          res;
        bit          com;
    } ent_t;

    // Reference model: stores oldest-first; head is the slot index of q[0].
    ent_t q[$];
    int   head;
    bit   exp_rv, exp_hit, exp_stall;
    logic [31:0] exp_fdata;

    int passes = 0;
    int total  = 0;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    store_queue_if #(.SQ_SIZE(N), .XLEN(32)) sqi ();

    store_queue #(.SQ_SIZE(N), .XLEN(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sq      (sqi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        sqi.disp_valid = 1'b0;
        sqi.ex_valid   = 1'b0;
        sqi.ex_idx     = '0;
        sqi.ex_addr    = '0;
        sqi.ex_data    = '0;
        sqi.rt_valid   = 1'b0;
        sqi.squash     = 1'b0;
        sqi.ld_valid   = 1'b0;
        sqi.ld_addr    = '0;
        sqi.ld_age     = '0;
        sqi.mem_wr_ack = 1'b0;
    endtask

    function automatic bit head_ready();
        return q.size() > 0 && q[0].com && q[0].res;
    endfunction

    // Older stores are the first k list entries; forwarding takes the youngest resolved match.
    task automatic model_lookup(input logic [31:0] la, input int age);
        int k, h;
        bit any;
        k = (age - head + N) % N;
        if (k > q.size()) k = q.size();
        h   = -1;
        any = 0;
`ifdef SQ_FWD_EN
        for (int j = k - 1; j >= 0; j--)
            if (h < 0 && q[j].res && q[j].addr[31:2] == la[31:2]) h = j;
        for (int j = 0; j < k; j++)
            if (!q[j].res && (h < 0 || j > h)) any = 1;
        exp_stall = any;
        exp_hit   = (h >= 0) && !any;
        exp_fdata = exp_hit ? q[h].data : 32'h0;
`else
        for (int j = 0; j < k; j++)
            if (!q[j].res || q[j].addr[31:2] == la[31:2]) any = 1;
        exp_stall = any;
        exp_hit   = 0;
        exp_fdata = 32'h0;
`endif
    endtask

    task automatic check_outputs(input string sfx);
        bit mv;
        mv = head_ready();
        check({"disp_ready", sfx}, 32'(sqi.disp_ready), 32'(q.size() < N));
        check({"disp_idx", sfx}, 32'(sqi.disp_idx), 32'((head + q.size()) % N));
        check({"mem_wr_valid", sfx}, 32'(sqi.mem_wr_valid), 32'(mv));
        if (mv) begin
            check({"mem_wr_addr", sfx}, sqi.mem_wr_addr, q[0].addr);
            check({"mem_wr_data", sfx}, sqi.mem_wr_data, q[0].data);
        end
        check({"ld_resp_valid", sfx}, 32'(sqi.ld_resp_valid), 32'(exp_rv));
        check({"fwd_hit", sfx}, 32'(sqi.fwd_hit), 32'(exp_hit));
        check({"fwd_stall", sfx}, 32'(sqi.fwd_stall), 32'(exp_stall));
        check({"fwd_data", sfx}, sqi.fwd_data, exp_fdata);
    endtask

    // Predict one clock edge from the current inputs, take the edge, compare, then drop all inputs.
    task automatic step(input string sfx);
        bit   full, ack;
        int   p;
        ent_t e;
        if (sqi.ld_valid) begin
            exp_rv = 1;
            model_lookup(sqi.ld_addr, int'(sqi.ld_age));
        end else begin
            exp_rv = 0; exp_hit = 0; exp_stall = 0; exp_fdata = 32'h0;
        end
        full = (q.size() == N);
        ack  = head_ready() && sqi.mem_wr_ack;
        if (sqi.squash) begin
            while (q.size() > 0 && !q[q.size() - 1].com) void'(q.pop_back());
        end else begin
            if (sqi.ex_valid) begin
                p = (int'(sqi.ex_idx) - head + N) % N;
                if (p < q.size() && !(q[p].com && q[p].res)) begin
                    e = q[p];
                    e.res = 1; e.addr = sqi.ex_addr; e.data = sqi.ex_data;
                    q[p] = e;
                end
            end
            if (sqi.rt_valid) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (!q[j].com) begin
                        e = q[j]; e.com = 1; q[j] = e;
                        break;
                    end
                end
            end
            if (sqi.disp_valid && !full) begin
                e.addr = 32'h0; e.data = 32'h0; e.res = 0; e.com = 0;
                q.push_back(e);
            end
        end
        if (ack) begin
            void'(q.pop_front());
            head = (head + 1) % N;
        end
        @(posedge clock);
        #1;
        clear_inputs();
        check_outputs(sfx);
    endtask

    task automatic model_reset();
        q.delete();
        head = 0;
        exp_rv = 0; exp_hit = 0; exp_stall = 0; exp_fdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("@reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic ex(input int idx, input logic [31:0] a, input logic [31:0] d);
        sqi.ex_valid = 1'b1;
        sqi.ex_idx   = PW'(idx);
        sqi.ex_addr  = a;
        sqi.ex_data  = d;
    endtask

    task automatic load(input logic [31:0] a, input int age);
        sqi.ld_valid = 1'b1;
        sqi.ld_addr  = a;
        sqi.ld_age   = PW'(age);
    endtask

    logic [31:0] addr_pool [4];

    initial begin
        int uncm, occ;
        addr_pool[0] = 32'h100; addr_pool[1] = 32'h104;
        addr_pool[2] = 32'h200; addr_pool[3] = 32'h40;
        clear_inputs();
        do_reset();

        // Fill the queue, then one more dispatch that must be dropped.
        for (int i = 0; i <= N; i++) begin
            sqi.disp_valid = 1'b1;
            step("/fill");
        end

        // Youngest matching older store supplies the data.
        do_reset();
        repeat (3) begin sqi.disp_valid = 1'b1; step("/fwd"); end
        ex(0, 32'h100, 32'hAA); step("/fwd");
        ex(1, 32'h300, 32'hCC); step("/fwd");
        ex(2, 32'h100, 32'hBB); step("/fwd");
        load(32'h100, 3); step("/fwd_ld");
        load(32'h102, 0); step("/fwd_noold");

        // Unresolved store younger than the match blocks forwarding until resolved.
        do_reset();
        repeat (3) begin sqi.disp_valid = 1'b1; step("/stl"); end
        ex(0, 32'h100, 32'hAA); step("/stl");
        ex(1, 32'h200, 32'h55); step("/stl");
        load(32'h100, 3); step("/stl_ld");
        ex(2, 32'h204, 32'h77); step("/stl");
        load(32'h100, 3); step("/stl_retry");

        // Commit two of four, squash the rest, then drain the survivors.
        do_reset();
        repeat (4) begin sqi.disp_valid = 1'b1; step("/sq"); end
        for (int i = 0; i < 4; i++) begin
            ex(i, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i));
            if (i < 2) sqi.rt_valid = 1'b1;
            step("/sq");
        end
        sqi.squash = 1'b1; sqi.disp_valid = 1'b1; step("/squash");
        sqi.disp_valid = 1'b1; step("/sq_disp");
        repeat (3) begin sqi.mem_wr_ack = 1'b1; step("/sq_drain"); end

        // Wrap around the end of the ring, forward across it, then stall the drain.
        do_reset();
        repeat (6) begin sqi.disp_valid = 1'b1; step("/wr"); end
        for (int i = 0; i < 6; i++) begin
            ex(i, 32'h1000 + 32'(4 * i), 32'(i)); sqi.rt_valid = 1'b1; step("/wr");
        end
        repeat (6) begin sqi.mem_wr_ack = 1'b1; step("/wr_drain"); end
        repeat (3) begin sqi.disp_valid = 1'b1; step("/wr_disp"); end
        ex(0, 32'h40, 32'h11); step("/wr");
        load(32'h40, 1); step("/wr_ld");
        ex(6, 32'h60, 32'h66); sqi.rt_valid = 1'b1; step("/wr");
        ex(7, 32'h70, 32'h77); sqi.rt_valid = 1'b1; step("/wr");
        sqi.rt_valid = 1'b1; step("/wr");
        repeat (3) step("/wr_hold");

        // Asynchronous reset in the middle of a pending drain with a live lookup response.
        load(32'h40, 1); step("/mid");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("/async_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) begin sqi.mem_wr_ack = 1'b1; step("/post_rst"); end

        // Random traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            occ  = q.size();
            uncm = 0;
            for (int j = 0; j < occ; j++) if (!q[j].com) uncm++;
            sqi.disp_valid = ($urandom_range(0, 99) < 55);
            sqi.ex_valid   = (occ > 0) && ($urandom_range(0, 99) < 60);
            sqi.ex_idx     = PW'((head + $urandom_range(0, (occ > 0) ? occ - 1 : 0)) % N);
            sqi.ex_addr    = addr_pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            sqi.ex_data    = $urandom;
            sqi.rt_valid   = (uncm > 0) && ($urandom_range(0, 99) < 40);
            sqi.squash     = ($urandom_range(0, 99) < 3);
            sqi.ld_valid   = ($urandom_range(0, 99) < 50);
            sqi.ld_addr    = addr_pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            sqi.ld_age     = PW'((head + $urandom_range(0, (occ == N) ? N - 1 : occ)) % N);
            sqi.mem_wr_ack = ($urandom_range(0, 99) < 50);
            step("/rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
